inst_mem_loader: RTL and testbench

INST_MEM_LOADER -- requirements
Module: inst_mem_loader

---
 rtl/inst_mem_loader_pkg.sv | 29 ++
 rtl/byte_packer.sv | 58 +++++
 rtl/inst_mem_loader.sv | 167 ++++++++++++++++
 tb/tb_inst_mem_loader.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// inst_mem_loader_pkg
// Shared definitions for the instruction-memory loader: the loader FSM state
// encoding, the width of the little-endian word-count field that prefixes
// every program image, and a helper that decides whether a count is loadable.
// -----------------------------------------------------------------------------
package inst_mem_loader_pkg;

   // Width of the word-count field sent ahead of the program bytes.
   localparam int LEN_W = 16;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_LEN_LO = 3'd1,
      S_LEN_HI = 3'd2,
      S_DATA   = 3'd3,
      S_WRITE  = 3'd4,
      S_DONE   = 3'd5,
      S_ERROR  = 3'd6
   } state_t;

   // A load is accepted only for 1..max_words words. The extra MSB on
   // max_words lets the limit be compared without truncation.
   function automatic logic len_ok(input logic [LEN_W-1:0] len,
                                   input logic [LEN_W:0]   max_words);
      return (len != '0) && ({1'b0, len} <= max_words);
   endfunction

endpackage

// File: rtl/byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Collects program bytes little-endian into a 32-bit instruction word.
//
// Ports
//   clock      in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   clear      in   restart packing at byte 0 (start of a new load)
//   byte_vld   in   byte_in is accepted this cycle
//   byte_in    in   program byte
//   word       out  partial word with the current byte already merged in;
//                   complete when word_done is high
//   word_done  out  the byte accepted this cycle is the 4th of the word
// -----------------------------------------------------------------------------
module byte_packer (
   input  logic        clock,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_vld,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        word_done
);

   logic [1:0]  idx_q, idx_d;
   logic [31:0] word_q, word_d;

   always_comb begin
      // Merge the incoming byte combinationally so the owner can capture the
      // finished word on the same edge the 4th byte is accepted.
      word = word_q;
      word[{idx_q, 3'b000} +: 8] = byte_in;

      word_done = byte_vld && !clear && (idx_q == 2'd3);

      idx_d  = idx_q;
      word_d = word_q;
      if (clear) begin
         idx_d  = 2'd0;
         word_d = '0;
      end else if (byte_vld) begin
         // idx wraps 3 -> 0, ready for the next word.
         idx_d  = idx_q + 2'd1;
         word_d = word;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         idx_q  <= 2'd0;
         word_q <= '0;
      end else begin
         idx_q  <= idx_d;
         word_q <= word_d;
      end
   end

endmodule

// File: rtl/inst_mem_loader.sv
// -----------------------------------------------------------------------------
// inst_mem_loader
// Loads a program image from a byte stream into instruction memory while the
// core is held in reset. Stream format: 16-bit word count (low byte first),
// then count x 4 bytes, each word little-endian. Word i is written to
// address i, matching the core's PC increment of 1 per instruction.
//
// Ports
//   clock           in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   start           in   one-cycle load request (ignored while busy)
//   rx_valid        in   byte available on rx_data
//   rx_data[7:0]    in   program byte
//   rx_ready        out  byte accepted when rx_valid && rx_ready
//   wr_en           out  one-cycle write strobe per word
//   wr_addr[63:0]   out  word index of the write
//   wr_data[31:0]   out  instruction word
//   core_reset      out  high holds the core in reset; low only after a
//                        successful load
//   busy            out  load in progress
//   done            out  last load completed
//   error           out  last load rejected (bad word count)
//   core_imem_rd    in   core instruction fetch strobe
//   core_imem_addr  in   core instruction fetch address
//   imem_we         out  instruction-memory write enable (loader side only)
//   imem_rd         out  instruction-memory read strobe (core side only)
//   imem_addr       out  instruction-memory address
//   imem_wdata      out  instruction-memory write data
// -----------------------------------------------------------------------------
module inst_mem_loader
   import inst_mem_loader_pkg::*;
#(
   parameter int MAX_WORDS = 1024
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   output logic        rx_ready,
   output logic        wr_en,
   output logic [63:0] wr_addr,
   output logic [31:0] wr_data,
   output logic        core_reset,
   output logic        busy,
   output logic        done,
   output logic        error,
   input  logic        core_imem_rd,
   input  logic [63:0] core_imem_addr,
   output logic        imem_we,
   output logic        imem_rd,
   output logic [63:0] imem_addr,
   output logic [31:0] imem_wdata
);

   localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MAX_WORDS);

   state_t             state_q, state_d;
   logic [LEN_W-1:0]   count_q, count_d;
   logic [LEN_W-1:0]   word_idx_q, word_idx_d;
   logic [63:0]        wr_addr_q, wr_addr_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic [LEN_W:0]     idx_next;

   logic               pk_clear;
   logic               pk_vld;
   logic [31:0]        pk_word;
   logic               pk_done;

   byte_packer u_byte_packer (
      .clock     (clock),
      .reset     (reset),
      .clear     (pk_clear),
      .byte_vld  (pk_vld),
      .byte_in   (rx_data),
      .word      (pk_word),
      .word_done (pk_done)
   );

   // One bit wider than the index so the last-word test cannot alias.
   assign idx_next = {1'b0, word_idx_q} + {{LEN_W{1'b0}}, 1'b1};

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      pk_clear   = 1'b0;
      pk_vld     = 1'b0;

      case (state_q)
         S_IDLE, S_DONE, S_ERROR: begin
            if (start) begin
               state_d    = S_LEN_LO;
               count_d    = '0;
               word_idx_d = '0;
               pk_clear   = 1'b1;
            end
         end
         S_LEN_LO: begin
            if (rx_valid) begin
               count_d = {count_q[LEN_W-1:8], rx_data};
               state_d = S_LEN_HI;
            end
         end
         S_LEN_HI: begin
            if (rx_valid) begin
               count_d = {rx_data, count_q[7:0]};
               state_d = len_ok({rx_data, count_q[7:0]}, MAX_LEN) ? S_DATA : S_ERROR;
            end
         end
         S_DATA: begin
            pk_vld = rx_valid;
            // Capture address and word here so both are stable for the
            // whole WRITE cycle and hold afterwards.
            if (pk_done) begin
               wr_addr_d = {{(64-LEN_W){1'b0}}, word_idx_q};
               wr_data_d = pk_word;
               state_d   = S_WRITE;
            end
         end
         S_WRITE: begin
            if (idx_next == {1'b0, count_q}) begin
               state_d = S_DONE;
            end else begin
               word_idx_d = idx_next[LEN_W-1:0];
               state_d    = S_DATA;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q    <= S_IDLE;
         count_q    <= '0;
         word_idx_q <= '0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
      end
   end

   assign rx_ready   = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
   assign busy       = rx_ready || (state_q == S_WRITE);
   assign wr_en      = (state_q == S_WRITE);
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign done       = (state_q == S_DONE);
   assign error      = (state_q == S_ERROR);
   assign core_reset = (state_q != S_DONE);

   // The loader owns the memory port whenever the core is held in reset;
   // the core can only fetch once it is released.
   assign imem_we    = core_reset ? wr_en     : 1'b0;
   assign imem_rd    = core_reset ? 1'b0      : core_imem_rd;
   assign imem_addr  = core_reset ? wr_addr   : core_imem_addr;
   assign imem_wdata = core_reset ? wr_data   : 32'h0;

endmodule

// File: tb/tb_inst_mem_loader.sv
module tb_inst_mem_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        rx_valid = 1'b0;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_ready;
   logic        wr_en;
   logic [63:0] wr_addr;
   logic [31:0] wr_data;
   logic        core_reset;
   logic        busy;
   logic        done;
   logic        error;
   logic        core_imem_rd = 1'b1;
   logic [63:0] core_imem_addr = 64'h0000_0000_0000_0A5C;
   logic        imem_we;
   logic        imem_rd;
   logic [63:0] imem_addr;
   logic [31:0] imem_wdata;

   always #5 clock = ~clock;

   inst_mem_loader #(.MAX_WORDS(1024)) dut (
      .clock          (clock),
      .reset          (reset),
      .start          (start),
      .rx_valid       (rx_valid),
      .rx_data        (rx_data),
      .rx_ready       (rx_ready),
      .wr_en          (wr_en),
      .wr_addr        (wr_addr),
      .wr_data        (wr_data),
      .core_reset     (core_reset),
      .busy           (busy),
      .done           (done),
      .error          (error),
      .core_imem_rd   (core_imem_rd),
      .core_imem_addr (core_imem_addr),
      .imem_we        (imem_we),
      .imem_rd        (imem_rd),
      .imem_addr      (imem_addr),
      .imem_wdata     (imem_wdata)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Transaction-level model: status flags and the write expected next cycle.
   bit          m_busy = 1'b0;
   bit          m_done = 1'b0;
   bit          m_err  = 1'b0;
   bit          m_wr   = 1'b0;
   bit          m_last = 1'b0;
   logic [63:0] m_addr = 64'h0;
   logic [31:0] m_data = 32'h0;
   logic [95:0] wlog[$];

   task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Per-cycle compare against the model.
   always @(negedge clock) begin
      chk("wr_en",      96'(wr_en),      96'(m_wr));
      chk("wr_addr",    96'(wr_addr),    96'(m_addr));
      chk("wr_data",    96'(wr_data),    96'(m_data));
      chk("busy",       96'(busy),       96'(m_busy));
      chk("done",       96'(done),       96'(m_done));
      chk("error",      96'(error),      96'(m_err));
      chk("core_reset", 96'(core_reset), 96'(!m_done));
      chk("rx_ready",   96'(rx_ready),   96'(m_busy && !m_wr));
      chk("imem_we",    96'(imem_we),    96'(m_wr));
      chk("imem_rd",    96'(imem_rd),    96'(m_done && core_imem_rd));
      chk("imem_addr",  96'(imem_addr),  96'(m_done ? core_imem_addr : m_addr));
      chk("imem_wdata", 96'(imem_wdata), 96'(m_done ? 32'h0 : m_data));
      if (wr_en) wlog.push_back({wr_addr, wr_data});
      if (m_wr) begin
         m_wr = 1'b0;
         if (m_last) begin
            m_busy = 1'b0;
            m_done = 1'b1;
         end
      end
   end

   // Runs one load from IDLE/DONE/ERROR. stall_i: drop rx_valid 5 cycles after
   // byte stall_i. rst_i: pulse reset after byte rst_i and abandon the load.
   // start_i: pulse start together with byte start_i (must be ignored).
   task automatic do_load(input logic [7:0] b[$], input int stall_i,
                          input int rst_i, input int start_i);
      logic [15:0] len;
      bit          ok;
      logic [31:0] w;
      int          n;
      int          k;
      int          wi;
      w = 32'h0;
      wlog.delete();
      @(negedge clock);
      start = 1'b1;
      @(posedge clock);
      m_busy = 1'b1;
      m_done = 1'b0;
      m_err  = 1'b0;
      @(negedge clock);
      start = 1'b0;
      len = {b[1], b[0]};
      ok  = (len != 16'd0) && (len <= 16'd1024);
      for (int i = 0; i < b.size(); i++) begin
         if (i == start_i) start = 1'b1;
         rx_valid = 1'b1;
         rx_data  = b[i];
         n = 0;
         while (!rx_ready && n < 50) begin
            @(negedge clock);
            n++;
         end
         if (!rx_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL rx_ready_wait: got 0 for 50 cycles, expected 1");
            rx_valid = 1'b0;
            start = 1'b0;
            return;
         end
         @(posedge clock);
         if (i == 1 && !ok) begin
            m_busy = 1'b0;
            m_err  = 1'b1;
         end
         if (i >= 2) begin
            k  = (i - 2) % 4;
            wi = (i - 2) / 4;
            w[8*k +: 8] = b[i];
            if (k == 3) begin
               m_wr   = 1'b1;
               m_addr = 64'(wi);
               m_data = w;
               m_last = (wi == int'(len) - 1);
            end
         end
         @(negedge clock);
         start = 1'b0;
         if (i == stall_i) begin
            rx_valid = 1'b0;
            for (int s = 0; s < 5; s++) begin
               chk("stall_rx_ready", 96'(rx_ready), 96'(1));
               @(negedge clock);
            end
         end
         if (i == rst_i) begin
            rx_valid = 1'b0;
            #1 reset = 1'b0;
            m_busy = 1'b0; m_done = 1'b0; m_err = 1'b0;
            m_wr = 1'b0; m_addr = 64'h0; m_data = 32'h0;
            #1;
            chk("async_rst_core_reset", 96'(core_reset), 96'(1));
            chk("async_rst_busy",       96'(busy),       96'(0));
            chk("async_rst_wr_addr",    96'(wr_addr),    96'(0));
            @(negedge clock);
            #1 reset = 1'b1;
            return;
         end
      end
      rx_valid = 1'b0;
      repeat (2) @(negedge clock);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: simulation did not finish, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      logic [7:0] q[$];

      repeat (2) @(negedge clock);
      chk("reset_core_reset", 96'(core_reset), 96'(1));
      chk("reset_rx_ready",   96'(rx_ready),   96'(0));
      #1 reset = 1'b1;

      // Two-word program, rx_valid held high.
      q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
      do_load(q, -1, -1, -1);
      chk("basic_nwrites", 96'(wlog.size()), 96'(2));
      if (wlog.size() == 2) begin
         chk("basic_w0", wlog[0], {64'd0, 32'h0000_0013});
         chk("basic_w1", wlog[1], {64'd1, 32'h0010_0093});
      end
      chk("basic_done",       96'(done),       96'(1));
      chk("basic_core_reset", 96'(core_reset), 96'(0));

      // Reload from DONE with a start pulse during DATA that must be ignored.
      q = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
      do_load(q, -1, -1, 3);
      chk("reload_nwrites", 96'(wlog.size()), 96'(1));
      if (wlog.size() == 1) chk("reload_w0", wlog[0], {64'd0, 32'hDEAD_BEEF});
      chk("reload_done", 96'(done), 96'(1));

      // Zero length rejected.
      q = '{8'h00, 8'h00};
      do_load(q, -1, -1, -1);
      chk("zero_len_error",      96'(error),       96'(1));
      chk("zero_len_core_reset", 96'(core_reset),  96'(1));
      chk("zero_len_nwrites",    96'(wlog.size()), 96'(0));

      // Valid load straight out of ERROR.
      q = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
      do_load(q, -1, -1, -1);
      chk("after_err_nwrites", 96'(wlog.size()), 96'(1));
      if (wlog.size() == 1) chk("after_err_w0", wlog[0], {64'd0, 32'h1234_5678});
      chk("after_err_done", 96'(done), 96'(1));

      // Exactly MAX_WORDS words is accepted.
      q.delete();
      q.push_back(8'h00);
      q.push_back(8'h04);
      for (int wdx = 0; wdx < 1024; wdx++) begin
         q.push_back(8'(wdx));
         q.push_back(8'(wdx >> 8));
         q.push_back(8'hC3);
         q.push_back(8'h5A);
      end
      do_load(q, -1, -1, -1);
      chk("max_nwrites", 96'(wlog.size()), 96'(1024));
      if (wlog.size() == 1024) chk("max_last", wlog[1023], {64'd1023, 32'h5AC3_03FF});
      chk("max_done", 96'(done), 96'(1));

      // One word over the limit.
      q = '{8'h01, 8'h04};
      do_load(q, -1, -1, -1);
      chk("over_len_error",   96'(error),       96'(1));
      chk("over_len_nwrites", 96'(wlog.size()), 96'(0));

      // rx_valid stalls mid-word.
      q = '{8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
      do_load(q, 7, -1, -1);
      chk("stall_nwrites", 96'(wlog.size()), 96'(2));
      if (wlog.size() == 2) begin
         chk("stall_w0", wlog[0], {64'd0, 32'h4433_2211});
         chk("stall_w1", wlog[1], {64'd1, 32'h8877_6655});
      end

      // Reset mid-load after two bytes of word 1, then a fresh load.
      q = '{8'h02, 8'h00, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
      do_load(q, -1, 7, -1);
      chk("abort_nwrites", 96'(wlog.size()), 96'(1));
      q = '{8'h01, 8'h00, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
      do_load(q, -1, -1, -1);
      chk("post_rst_nwrites", 96'(wlog.size()), 96'(1));
      if (wlog.size() == 1) chk("post_rst_w0", wlog[0], {64'd0, 32'hC4C3_C2C1});
      chk("post_rst_done", 96'(done), 96'(1));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
